// File: rtl/i2c_target_fsm.sv
// I2C target with a 7-bit address, synchronized SCL/SDA, and byte-level rx/tx handshakes.
// Define I2C_TARGET_CLK_STRETCH_EN to hold SCL low in TX_LOAD until tx_valid arrives.
module i2c_target_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic [6:0] own_addr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sda_oen,
  output logic       scl_oen,
  output logic       busy,
  output logic       addressed,
  output logic       rw,
  output logic       nack_rcvd,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_prev, sda_prev;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  always_ff @(posedge clk) begin
    if (rst_) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign sda_rise  = sda_s & ~sda_prev;
  assign sda_fall  = ~sda_s & sda_prev;
  // SCL must be high on both sides of the SDA edge to count as START/STOP.
  assign start_det = sda_fall & scl_s & scl_prev;
  assign stop_det  = sda_rise & scl_s & scl_prev;

  state_t     state, state_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic [6:0] shreg, shreg_d;
  logic [6:0] addr_q, addr_d;
  logic       sda_oen_d, scl_oen_d, busy_d, addressed_d, rw_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d, tx_ack_d, nack_d;

  always_ff @(posedge clk) begin
    if (rst_) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 7'd0;
      addr_q    <= 7'd0;
      sda_oen   <= 1'b0;
      scl_oen   <= 1'b0;
      busy      <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_ack    <= 1'b0;
      nack_rcvd <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      addr_q    <= addr_d;
      sda_oen   <= sda_oen_d;
      scl_oen   <= scl_oen_d;
      busy      <= busy_d;
      addressed <= addressed_d;
      rw        <= rw_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      tx_ack    <= tx_ack_d;
      nack_rcvd <= nack_d;
    end
  end

  // Handshakes: tx_ack pulses on the cycle after the clock edge where tx_valid was
  // taken together with tx_data; rx_valid pulses for one cycle with rx_data already valid.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shreg_d     = shreg;
    addr_d      = addr_q;
    sda_oen_d   = sda_oen;
    scl_oen_d   = scl_oen;
    busy_d      = busy;
    addressed_d = addressed;
    rw_d        = rw;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;
    nack_d      = 1'b0;

    if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = 4'd0;
      addr_d      = own_addr;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      sda_oen_d   = 1'b0;
      scl_oen_d   = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      bit_cnt_d   = 4'd0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_oen_d   = 1'b0;
      scl_oen_d   = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_d   = {shreg[5:0], sda_s};
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (shreg == addr_q) begin
              addressed_d = 1'b1;
              rw_d        = sda_s;
              state_d     = ADDR_ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
        // First fall after the byte starts the ACK, the next fall ends it.
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!sda_oen) begin
            sda_oen_d = 1'b1;
          end else begin
            sda_oen_d = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = (state == ADDR_ACK && rw) ? TX_LOAD : RX_BYTE;
          end
        end
        RX_BYTE: if (scl_rise) begin
          shreg_d   = {shreg[5:0], sda_s};
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rx_data_d  = {shreg, sda_s};
            rx_valid_d = 1'b1;
            state_d    = RX_ACK;
          end
        end
        // Entered just after an SCL fall, so bit 7 goes out while SCL is still low.
        TX_LOAD: begin
          if (tx_valid) begin
            shreg_d   = tx_data[6:0];
            sda_oen_d = ~tx_data[7];
            tx_ack_d  = 1'b1;
            bit_cnt_d = 4'd0;
            scl_oen_d = 1'b0;
            state_d   = TX_BYTE;
          end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
            scl_oen_d = 1'b1;
`else
            shreg_d   = 7'h7F;
            sda_oen_d = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = TX_BYTE;
`endif
          end
        end
        TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oen_d = 1'b0;
              state_d   = TX_ACK;
            end else begin
              sda_oen_d = ~shreg[6];
              shreg_d   = {shreg[5:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && sda_s) begin
            nack_d      = 1'b1;
            addressed_d = 1'b0;
            state_d     = IDLE;
          end else if (scl_fall) begin
            state_d = TX_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_i2c_target_fsm.sv
// Bench for i2c_target_fsm: a bit-banged bus master, a byte-level reference model
// feeding expected queues, and a negedge monitor that checks DUT pulses against them.
module tb_i2c_target_fsm;
  localparam int Q   = 8;
  localparam int H   = 16;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic [6:0] own_addr = 7'h42;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ack, rx_valid, sda_oen, scl_oen, busy, addressed, rw, nack_rcvd;
  logic [7:0] rx_data;
  logic [2:0] state_dbg;

  wire scl_line = scl_m & ~scl_oen;
  wire sda_line = sda_m & ~sda_oen;

  int errors = 0, checks = 0;
  int tx_ack_cnt = 0, nack_cnt = 0, rx_cnt = 0, oen_hi_cnt = 0, scl_hold_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_src_q[$];
  logic [7:0] pay_q[$];
  logic       oen_prev = 1'b0;

  i2c_target_fsm #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_(rst_), .scl_i(scl_line), .sda_i(sda_line),
    .own_addr(own_addr), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .sda_oen(sda_oen), .scl_oen(scl_oen),
    .busy(busy), .addressed(addressed), .rw(rw), .nack_rcvd(nack_rcvd),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef I2C_TARGET_CLK_STRETCH_EN
  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask
`endif

  // Monitor: pops expected rx bytes, tracks pulses, and feeds the tx source queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid_unexpected: got data %0h, expected no rx_valid", rx_data);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (tx_ack) begin
        tx_ack_cnt++;
        if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
      end
      if (nack_rcvd) nack_cnt++;
      if (sda_oen) oen_hi_cnt++;
      if (scl_oen) scl_hold_cnt++;
      if (sda_oen !== oen_prev) check("sda_oen_change_scl_low", scl_line, 1'b0);
      oen_prev = sda_oen;
      tx_valid = (tx_src_q.size() > 0);
      tx_data  = tx_valid ? tx_src_q[0] : 8'h00;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl();
    int n = 0;
    while (scl_line !== 1'b1 && n < TMO) begin
      tick(1);
      n++;
    end
    if (scl_line !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL scl_release_timeout: scl low after %0d cycles, expected high", n);
    end
  endtask

  task automatic put_bit(input logic b);
    tick(Q); sda_m = b; tick(Q); scl_m = 1'b1; wait_scl(); tick(H); scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(2*Q); scl_m = 1'b1; wait_scl(); tick(H/2);
    b = sda_line; tick(H/2); scl_m = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; wait_scl(); tick(H); sda_m = 1'b0; tick(H); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b1; wait_scl(); tick(H); sda_m = 1'b1; tick(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(x);
    ack = ~x;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      b[i] = x;
    end
    put_bit(~mack);
  endtask

  // Write transfer of pay_q; the target only responds if the address matches.
  task automatic do_write(input logic [6:0] own, input logic [7:0] abyte);
    logic ack, match;
    int   oen0;
    match = (abyte[7:1] == own);
    own_addr = own;
    if (match) foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    oen0 = oen_hi_cnt;
    bus_start();
    check("busy_after_start", busy, 1'b1);
    write_byte(abyte, ack);
    check("addr_ack", ack, match);
    check("addressed", addressed, match);
    if (match) check("rw_write", rw, 1'b0);
    foreach (pay_q[i]) begin
      write_byte(pay_q[i], ack);
      check("data_ack", ack, match);
    end
    bus_stop();
    check("busy_after_stop", busy, 1'b0);
    check("addressed_after_stop", addressed, 1'b0);
    check("rx_outstanding", exp_q.size(), 0);
    if (!match) check("sda_quiet_unaddressed", oen_hi_cnt - oen0, 0);
  endtask

  // Read transfer: master ACKs every byte of pay_q except the last, which it NACKs.
  task automatic do_read(input logic [6:0] own);
    logic       ack;
    logic [7:0] got;
    int         tx0, nk0;
    own_addr = own;
    tx0 = tx_ack_cnt;
    nk0 = nack_cnt;
    foreach (pay_q[i]) tx_src_q.push_back(pay_q[i]);
    bus_start();
    write_byte({own, 1'b1}, ack);
    check("rd_addr_ack", ack, 1'b1);
    check("rd_addressed", addressed, 1'b1);
    check("rd_rw", rw, 1'b1);
    foreach (pay_q[i]) begin
      read_byte(got, i != pay_q.size() - 1);
      check("rd_byte", got, pay_q[i]);
    end
    check("nack_pulses", nack_cnt - nk0, 1);
    check("addressed_after_nack", addressed, 1'b0);
    bus_stop();
    check("tx_ack_pulses", tx_ack_cnt - tx0, pay_q.size());
    check("busy_after_stop", busy, 1'b0);
  endtask

  initial begin
    logic       ack, x;
    logic [7:0] got;
    logic [6:0] own, other;
    int         tx0, rx0, h0, kind, n;

    tick(5);
    check("rst_sda_oen", sda_oen, 1'b0);
    check("rst_scl_oen", scl_oen, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addressed", addressed, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {rx_valid, tx_ack, nack_rcvd}, 3'b000);
    rst_ = 1'b0;
    tick(5);
    check("idle_busy", busy, 1'b0);

    pay_q = '{8'hA5, 8'h3C};
    do_write(7'h42, 8'h84);

    pay_q = '{8'h11};
    do_write(7'h42, 8'h86);

    pay_q = '{8'h5A, 8'hC3};
    do_read(7'h42);

    // Repeated START in the middle of a write byte, then a read.
    own_addr = 7'h42;
    tx0 = tx_ack_cnt;
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'h84, ack);
    check("rs_addr_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom_range(0, 1)));
    tx_src_q.push_back(8'h69);
    bus_start();
    check("rs_addressed_cleared", addressed, 1'b0);
    write_byte(8'h85, ack);
    check("rs_read_ack", ack, 1'b1);
    check("rs_rw", rw, 1'b1);
    read_byte(got, 1'b0);
    check("rs_byte", got, 8'h69);
    bus_stop();
    check("rs_no_rx_valid", rx_cnt - rx0, 0);
    check("rs_tx_ack", tx_ack_cnt - tx0, 1);

    // Read with no tx byte ready when the data phase begins.
    own_addr = 7'h42;
    tx0 = tx_ack_cnt;
    h0 = scl_hold_cnt;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    fork
      begin
        int w;
        w = 0;
        while (scl_oen !== 1'b1 && w < 2000) begin
          tick(1);
          w++;
        end
        tick(50);
        tx_src_q.push_back(8'h96);
      end
    join_none
`endif
    bus_start();
    write_byte(8'h85, ack);
    check("late_addr_ack", ack, 1'b1);
    read_byte(got, 1'b0);
    bus_stop();
`ifdef I2C_TARGET_CLK_STRETCH_EN
    check("stretch_byte", got, 8'h96);
    check("stretch_tx_ack", tx_ack_cnt - tx0, 1);
    check_range("stretch_len", scl_hold_cnt - h0, 46, 56);
`else
    check("fill_byte", got, 8'hFF);
    check("fill_no_tx_ack", tx_ack_cnt - tx0, 0);
    check("no_stretch", scl_hold_cnt - h0, 0);
`endif

    // Reset in the middle of a transmitted byte.
    own_addr = 7'h42;
    tx_src_q.push_back(8'hA7);
    bus_start();
    write_byte(8'h85, ack);
    for (int i = 0; i < 3; i++) get_bit(x);
    tick(4);
    check("pre_reset_busy", busy, 1'b1);
    rst_ = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_sda_oen", sda_oen, 1'b0);
    check("mid_rst_scl_oen", scl_oen, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addressed", addressed, 1'b0);
    check("mid_rst_rw", rw, 1'b0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_pulses", {rx_valid, tx_ack, nack_rcvd}, 3'b000);
    check("mid_rst_sda_line", sda_line, 1'b1);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    bus_stop();
    check("post_rst_busy", busy, 1'b0);

    for (int t = 0; t < 12; t++) begin
      own  = 7'($urandom_range(0, 127));
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
      case (kind)
        0: do_write(own, {own, 1'b0});
        1: begin
          other = own ^ 7'($urandom_range(1, 127));
          do_write(own, {other, 1'b0});
        end
        default: do_read(own);
      endcase
    end

    tick(10);
    check("final_rx_queue_empty", exp_q.size(), 0);
    check("final_tx_queue_empty", tx_src_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
